// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS datapath.
//   WIDTH_DEFAULT : default datapath width
//   OP_*          : primary opcode field values (instr[31:26])
//   pcsrc_t       : next-PC source select driven by the main control FSM
package mips_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    PC_ALURES = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10,
    PC_HOLD   = 2'b11
  } pcsrc_t;

endpackage

// File: rtl/flopenr.sv
// Register with enable and asynchronous active-low reset.
//   clk   : clock, q updates on posedge when en=1
//   reset : asynchronous reset, active low; q <= RST
//   en    : load enable
//   d     : next value
//   q     : registered value
module flopenr #(
  parameter int           W   = 32,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RST;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_ir_unit.sv
// PC / IR / datapath register block of the multi-cycle MIPS core.
// Holds PC, IR, MDR, A, B and ALUOut, selects the memory address and the
// next PC, and keeps fetch and cycle counters for bring-up.
//   clk, reset          : clock and asynchronous active-low reset
//   pcwrite, branch     : unconditional / zero-qualified PC write
//   irwrite             : load IR from readdata
//   iord                : address select, 0 = pc, 1 = aluout
//   pcsrc               : next-PC select (see mips_pkg::pcsrc_t)
//   zero, aluresult     : ALU flag and combinational result
//   readdata            : memory read data
//   rd1, rd2            : register file read ports
//   adr                 : memory address
//   pc, instr, op, funct: program counter, IR and its decoded fields
//   data, a, b, aluout  : MDR, operand registers, registered ALU result
//   fetchcnt, cyclecnt  : IR loads / clock cycles since reset
module pc_ir_unit
  import mips_pkg::*;
#(
  parameter int               WIDTH    = WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcwrite,
  input  logic             branch,
  input  logic             irwrite,
  input  logic             iord,
  input  logic [1:0]       pcsrc,
  input  logic             zero,
  input  logic [WIDTH-1:0] aluresult,
  input  logic [WIDTH-1:0] readdata,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] instr,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] aluout,
  output logic [CNT_W-1:0] fetchcnt,
  output logic [CNT_W-1:0] cyclecnt
);

  logic             pcen;
  logic [WIDTH-1:0] pcnext;
  logic [CNT_W-1:0] fetchcnt_nxt;
  logic [CNT_W-1:0] cyclecnt_nxt;

  assign pcen = pcwrite | (branch & zero);

  // Jump target keeps the upper nibble of the current pc, which already
  // holds PC+4 once FETCH has completed.
  always_comb begin
    pcnext = pc;
    case (pcsrc_t'(pcsrc))
      PC_ALURES: pcnext = aluresult;
      PC_ALUOUT: pcnext = aluout;
      PC_JUMP:   pcnext = {pc[31:28], instr[25:0], 2'b00};
      PC_HOLD:   pcnext = pc;
      default:   pcnext = pc;
    endcase
  end

  flopenr #(.W(WIDTH), .RST(RESET_PC)) u_pc_reg (
    .clk(clk), .reset(reset), .en(pcen), .d(pcnext), .q(pc)
  );

  // IR samples memory at the pre-update address, so a FETCH cycle with
  // irwrite and pcwrite both set loads the word at the old pc.
  flopenr #(.W(WIDTH)) u_ir_reg (
    .clk(clk), .reset(reset), .en(irwrite), .d(readdata), .q(instr)
  );

  flopenr #(.W(WIDTH)) u_mdr_reg (
    .clk(clk), .reset(reset), .en(1'b1), .d(readdata), .q(data)
  );

  flopenr #(.W(WIDTH)) u_a_reg (
    .clk(clk), .reset(reset), .en(1'b1), .d(rd1), .q(a)
  );

  flopenr #(.W(WIDTH)) u_b_reg (
    .clk(clk), .reset(reset), .en(1'b1), .d(rd2), .q(b)
  );

  flopenr #(.W(WIDTH)) u_aluout_reg (
    .clk(clk), .reset(reset), .en(1'b1), .d(aluresult), .q(aluout)
  );

  // Both counters wrap modulo 2^CNT_W.
  assign fetchcnt_nxt = fetchcnt + CNT_W'(1);
  assign cyclecnt_nxt = cyclecnt + CNT_W'(1);

  flopenr #(.W(CNT_W)) u_fetchcnt_reg (
    .clk(clk), .reset(reset), .en(irwrite), .d(fetchcnt_nxt), .q(fetchcnt)
  );

  flopenr #(.W(CNT_W)) u_cyclecnt_reg (
    .clk(clk), .reset(reset), .en(1'b1), .d(cyclecnt_nxt), .q(cyclecnt)
  );

  assign adr   = iord ? aluout : pc;
  assign op    = instr[31:26];
  assign funct = instr[5:0];

endmodule

// File: tb/tb_pc_ir_unit.sv
module tb_pc_ir_unit;

  localparam logic [31:0] RPC = 32'h40;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcwrite, branch, irwrite, iord, zero;
  logic [1:0]  pcsrc;
  logic [31:0] aluresult, readdata, rd1, rd2;

  logic [31:0] adr, pc, instr, data, a, b, aluout;
  logic [5:0]  op, funct;
  logic [3:0]  fetchcnt, cyclecnt;

  logic [31:0] w_adr, w_pc, w_instr, w_data, w_a, w_b, w_aluout;
  logic [5:0]  w_op, w_funct;
  logic [31:0] w_fetchcnt, w_cyclecnt;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model state
  logic [31:0] m_pc, m_instr, m_data, m_a, m_b, m_aluout;
  int unsigned m_fcnt, m_ccnt;

  always #5 clk = ~clk;

  pc_ir_unit #(.WIDTH(32), .RESET_PC(RPC), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .pcwrite(pcwrite), .branch(branch), .irwrite(irwrite),
    .iord(iord), .pcsrc(pcsrc), .zero(zero), .aluresult(aluresult), .readdata(readdata),
    .rd1(rd1), .rd2(rd2), .adr(adr), .pc(pc), .instr(instr), .op(op), .funct(funct),
    .data(data), .a(a), .b(b), .aluout(aluout), .fetchcnt(fetchcnt), .cyclecnt(cyclecnt)
  );

  pc_ir_unit #(.WIDTH(32), .RESET_PC(RPC), .CNT_W(32)) u_wide (
    .clk(clk), .reset(reset), .pcwrite(pcwrite), .branch(branch), .irwrite(irwrite),
    .iord(iord), .pcsrc(pcsrc), .zero(zero), .aluresult(aluresult), .readdata(readdata),
    .rd1(rd1), .rd2(rd2), .adr(w_adr), .pc(w_pc), .instr(w_instr), .op(w_op), .funct(w_funct),
    .data(w_data), .a(w_a), .b(w_b), .aluout(w_aluout), .fetchcnt(w_fetchcnt),
    .cyclecnt(w_cyclecnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_instr = 0; m_data = 0; m_a = 0; m_b = 0; m_aluout = 0;
    m_fcnt = 0; m_ccnt = 0;
  endtask

  // One clock edge worth of architectural effect, from pre-edge values.
  task automatic model_edge();
    logic [31:0] nxt;
    nxt = m_pc;
    if (pcwrite || (branch && zero)) begin
      if (pcsrc == 2'd0)      nxt = aluresult;
      else if (pcsrc == 2'd1) nxt = m_aluout;
      else if (pcsrc == 2'd2) nxt = (m_pc & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
    end
    if (irwrite) begin
      m_instr = readdata;
      m_fcnt  = m_fcnt + 1;
    end
    m_pc     = nxt;
    m_data   = readdata;
    m_a      = rd1;
    m_b      = rd2;
    m_aluout = aluresult;
    m_ccnt   = m_ccnt + 1;
  endtask

  task automatic check_all();
    chk("pc",       pc,       m_pc);
    chk("instr",    instr,    m_instr);
    chk("op",       {26'b0, op},    m_instr >> 26);
    chk("funct",    {26'b0, funct}, m_instr % 64);
    chk("data",     data,     m_data);
    chk("a",        a,        m_a);
    chk("b",        b,        m_b);
    chk("aluout",   aluout,   m_aluout);
    chk("adr",      adr,      iord ? m_aluout : m_pc);
    chk("fetchcnt4",  {28'b0, fetchcnt}, m_fcnt % 16);
    chk("cyclecnt4",  {28'b0, cyclecnt}, m_ccnt % 16);
    chk("fetchcnt32", w_fetchcnt, m_fcnt);
    chk("cyclecnt32", w_cyclecnt, m_ccnt);
    chk("wide_pc",    w_pc,       m_pc);
  endtask

  task automatic idle_inputs();
    pcwrite = 0; branch = 0; irwrite = 0; iord = 0; zero = 0; pcsrc = 2'd0;
    aluresult = 0; readdata = 0; rd1 = 0; rd2 = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    model_reset();

    // 1: reset held
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h40);
    chk("rst_instr", instr, 32'h0);
    chk("rst_fcnt", {28'b0, fetchcnt}, 32'h0);
    chk("rst_ccnt", {28'b0, cyclecnt}, 32'h0);
    check_all();
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("ccnt_after_release", w_cyclecnt, 32'd1);

    // 2: fetch
    readdata = 32'h8C080004; irwrite = 1; pcwrite = 1; pcsrc = 2'b00; aluresult = pc + 4;
    step();
    chk("fetch_instr", instr, 32'h8C080004);
    chk("fetch_op", {26'b0, op}, 32'b100011);
    chk("fetch_pc", pc, 32'h44);
    chk("fetch_fcnt", w_fetchcnt, 32'd1);
    chk("fetch_adr", adr, 32'h44);

    // 3: beq taken / not taken
    idle_inputs(); aluresult = 32'h80;
    step();
    idle_inputs(); branch = 1; pcsrc = 2'b01; zero = 1; aluresult = 32'h1234;
    step();
    chk("beq_taken", pc, 32'h80);
    idle_inputs(); aluresult = 32'h200;
    step();
    idle_inputs(); branch = 1; pcsrc = 2'b01; zero = 0;
    step();
    chk("beq_not_taken", pc, 32'h80);

    // 4: jump and hold
    idle_inputs(); pcwrite = 1; pcsrc = 2'b00; aluresult = 32'h44;
    irwrite = 1; readdata = 32'h08000010;
    step();
    idle_inputs(); pcwrite = 1; pcsrc = 2'b10;
    step();
    chk("jump_pc", pc, 32'h40);
    idle_inputs(); pcwrite = 1; pcsrc = 2'b11; aluresult = 32'h999;
    step();
    chk("hold_pc", pc, 32'h40);

    // 5: asynchronous reset mid-instruction
    idle_inputs(); readdata = 32'hDEAD_BEEF; irwrite = 1; aluresult = 32'h5555_0000;
    step();
    idle_inputs();
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_instr", instr, 32'h0);
    chk("mid_rst_aluout", aluout, 32'h0);
    chk("mid_rst_pc", pc, 32'h40);
    check_all();
    @(negedge clk);
    reset = 1'b1;
    step();
    readdata = $urandom; irwrite = 1; pcwrite = 1; pcsrc = 2'b00; aluresult = 32'h44;
    #1;
    chk("refetch_adr", adr, 32'h40);
    step();

    // 6: counter wrap, then iord select
    for (int i = 0; i < 15; i++) begin
      idle_inputs(); irwrite = 1; readdata = $urandom;
      step();
    end
    chk("fcnt4_wrap", {28'b0, fetchcnt}, 32'h0);
    chk("fcnt32_16", w_fetchcnt, 32'd16);
    idle_inputs(); aluresult = 32'hCAFE_0010;
    step();
    iord = 1;
    #1;
    chk("iord_adr", adr, 32'hCAFE_0010);

    // randomized operation against the model
    for (int i = 0; i < 400; i++) begin
      pcwrite   = ($urandom_range(0, 3) == 0);
      branch    = $urandom_range(0, 1);
      zero      = $urandom_range(0, 1);
      irwrite   = $urandom_range(0, 1);
      iord      = $urandom_range(0, 1);
      pcsrc     = 2'($urandom_range(0, 3));
      aluresult = $urandom;
      readdata  = $urandom;
      rd1       = $urandom;
      rd2       = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
